// File: rtl/vx_mem_responder_pkg.sv
// Shared types and sizing helpers for the vx_mem_responder memory-side responder.
package vx_mem_responder_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  localparam int DEF_WORD_SIZE  = 4;
  localparam int DEF_ADDR_WIDTH = 30;
  localparam int DEF_TAG_WIDTH  = 8;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_RSP_DEPTH  = 4;

  // Counter must hold the value depth itself, not just depth-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vx_mem_responder_delay_line.sv
// Fixed-length valid/payload shift register; only the valid bits are reset.
module vx_mem_responder_delay_line
  import vx_mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q [LATENCY];
  logic [WIDTH-1:0] data_q  [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) valid_q[i] <= 1'b0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/vx_mem_responder.sv
// Word-array memory responder returning in-order tagged responses after a fixed latency.
// Build option VX_MEM_WRITE_ACK_EN: writes also return a zero-data acknowledge response.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [WORD_SIZE-1:0]   req_byteen,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_SIZE*8-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [WORD_SIZE*8-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic                   busy
);

  localparam int DATA_W = WORD_SIZE * 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(RSP_DEPTH);
  localparam int PTR_W  = ptr_width(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [DATA_W-1:0]    data;
  } mem_rsp_entry_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  mem_op_e           op;
  logic              req_fire;
  logic              rsp_fire;
  logic              rsp_push;
  logic [CNT_W-1:0]  outstanding;
  logic              unused_addr_hi;

  mem_rsp_entry_t    dl_in;
  mem_rsp_entry_t    dl_out;
  logic              dl_out_valid;

  mem_rsp_entry_t    fifo_mem [RSP_DEPTH];
  mem_rsp_entry_t    fifo_head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;

  // Upper address bits alias onto the same array word.
  assign idx            = req_addr[IDX_W-1:0];
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W];
  assign op             = mem_op_e'(req_rw);

  assign req_ready = reset && (outstanding < CNT_MAX);
  assign req_fire  = req_valid && req_ready;

`ifdef VX_MEM_WRITE_ACK_EN
  assign rsp_push = req_fire;
`else
  assign rsp_push = req_fire && (op == MEM_RD);
`endif

  assign dl_in.tag  = req_tag;
  assign dl_in.data = (op == MEM_WR) ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (req_fire && (op == MEM_WR)) begin
      for (int b = 0; b < WORD_SIZE; b++) begin
        if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  vx_mem_responder_delay_line #(
    .LATENCY (LATENCY),
    .WIDTH   ($bits(mem_rsp_entry_t))
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rsp_push),
    .in_data   (dl_in),
    .out_valid (dl_out_valid),
    .out_data  (dl_out)
  );

  // An empty FIFO is bypassed so the delay-line exit is presented directly.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_MAX);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign fifo_pop   = !fifo_empty && rsp_ready;
  assign fifo_push  = dl_out_valid && !(fifo_empty && rsp_ready);

  assign rsp_valid = !fifo_empty || dl_out_valid;
  assign rsp_tag   = fifo_empty ? dl_out.tag  : fifo_head.tag;
  assign rsp_data  = fifo_empty ? dl_out.data : fifo_head.data;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= dl_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) outstanding <= '0;
    else        outstanding <= outstanding + CNT_W'(rsp_push) - CNT_W'(rsp_fire);
  end

  assign busy = (outstanding != '0);

`ifndef SYNTHESIS
  a_cnt_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_fire && !rsp_push && (outstanding == '0)));
  a_fifo_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(fifo_push && fifo_full));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_tag) && $stable(rsp_data)));
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Scoreboard bench for vx_mem_responder: random and directed traffic against a queue-based model.
module tb_vx_mem_responder;

  localparam int WORD_SIZE  = 4;
  localparam int ADDR_WIDTH = 30;
  localparam int TAG_WIDTH  = 8;
  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 2;
  localparam int RSP_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [3:0]  req_byteen = '0;
  logic [29:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  req_tag = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        rsp_ready = 1'b1;
  logic        busy;

  vx_mem_responder #(
    .WORD_SIZE (WORD_SIZE), .ADDR_WIDTH (ADDR_WIDTH), .TAG_WIDTH (TAG_WIDTH),
    .DEPTH (DEPTH), .LATENCY (LATENCY), .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_rw (req_rw), .req_byteen (req_byteen),
    .req_addr (req_addr), .req_data (req_data), .req_tag (req_tag), .req_ready (req_ready),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_tag (rsp_tag),
    .rsp_ready (rsp_ready), .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
    int          rdy_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model_mem [DEPTH];
  int          cyc = 0;
  int          m_out = 0;
  int          vecs = 0;
  int          errs = 0;
  bit          rand_rdy = 1'b0;
  bit          exp_valid;
  logic [7:0]  last_tag = '0;
  logic [31:0] last_data = '0;
  logic [29:0] ra;
  int          nacc;

  always @(posedge clk) cyc++;

  // Model: a response becomes presentable LATENCY cycles after its accept and is
  // held at the head of the in-order stream until consumed.
  always @(negedge clk) begin
    if (!reset) begin
      vecs++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
        errs++;
        $display("FAIL reset_state: rsp_valid=%b busy=%b req_ready=%b, want 0 0 0", rsp_valid, busy, req_ready);
      end
      exp_q.delete();
      m_out = 0;
    end else begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy_cyc <= cyc);
      vecs++;
      if (rsp_valid !== exp_valid) begin
        errs++;
        $display("FAIL rsp_valid @%0d: got %b want %b", cyc, rsp_valid, exp_valid);
      end
      vecs++;
      if (req_ready !== (m_out < RSP_DEPTH)) begin
        errs++;
        $display("FAIL req_ready @%0d: got %b want %b", cyc, req_ready, m_out < RSP_DEPTH);
      end
      vecs++;
      if (busy !== (m_out != 0)) begin
        errs++;
        $display("FAIL busy @%0d: got %b want %b", cyc, busy, m_out != 0);
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        last_tag  = rsp_tag;
        last_data = rsp_data;
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL spurious_rsp @%0d: got tag %h, want no response", cyc, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          m_out--;
          vecs++;
          if (rsp_tag !== e.tag || rsp_data !== e.data) begin
            errs++;
            $display("FAIL rsp_payload @%0d: got tag %h data %h, want tag %h data %h",
                     cyc, rsp_tag, rsp_data, e.tag, e.data);
          end
        end
      end
      if (req_valid && req_ready === 1'b1) begin
        if (req_rw) begin
          for (int b = 0; b < 4; b++)
            if (req_byteen[b]) model_mem[req_addr % DEPTH][b*8 +: 8] = req_data[b*8 +: 8];
`ifdef VX_MEM_WRITE_ACK_EN
          exp_q.push_back('{tag: req_tag, data: 32'h0, rdy_cyc: cyc + LATENCY});
          m_out++;
`endif
        end else begin
          exp_q.push_back('{tag: req_tag, data: model_mem[req_addr % DEPTH], rdy_cyc: cyc + LATENCY});
          m_out++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic put_req(input logic rw, input logic [3:0] be, input logic [29:0] a,
                         input logic [31:0] d, input logic [7:0] t);
    req_valid = 1'b1; req_rw = rw; req_byteen = be; req_addr = a; req_data = d; req_tag = t;
  endtask

  task automatic wait_accept(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      vecs++; errs++;
      $display("FAIL accept_timeout: request tag %h not accepted in %0d cycles", req_tag, n);
    end
  endtask

  task automatic send(input logic rw, input logic [3:0] be, input logic [29:0] a,
                      input logic [31:0] d, input logic [7:0] t, output int n);
    put_req(rw, be, a, d, t);
    wait_accept(n);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_out != 0) && k < limit) begin
      @(posedge clk); #1; k++;
    end
    if (exp_q.size() != 0 || m_out != 0) begin
      vecs++; errs++;
      $display("FAIL drain_timeout: %0d responses still pending, want 0", exp_q.size());
    end
  endtask

  task automatic check_last(input string name, input logic [7:0] t, input logic [31:0] d);
    vecs++;
    if (last_tag !== t || last_data !== d) begin
      errs++;
      $display("FAIL %s: got tag %h data %h, want tag %h data %h", name, last_tag, last_data, t, d);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    for (int i = 0; i < 64; i++) send(1'b1, 4'hF, 30'(i), $urandom, 8'(i), nacc);
    wait_drain(100);

    // full-word write then read-back
    send(1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 8'h01, nacc);
    send(1'b0, 4'h0, 30'd5, 32'h0, 8'h11, nacc);
    wait_drain(50);
    check_last("full_write_read", 8'h11, 32'hDEADBEEF);

    // single-byte merge
    send(1'b1, 4'b0010, 30'd5, 32'h0000AB00, 8'h02, nacc);
    send(1'b0, 4'h0, 30'd5, 32'h0, 8'h12, nacc);
    wait_drain(50);
    check_last("partial_write", 8'h12, 32'hDEADABEF);

    // backpressure fills the outstanding budget
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 4'h0, 30'($urandom_range(0, 63)), 32'h0, 8'(8'h30 + i), nacc);
      vecs++;
      if (nacc != 1) begin errs++; $display("FAIL fill_accept: took %0d cycles, want 1", nacc); end
    end
    put_req(1'b0, 4'h0, 30'd7, 32'h0, 8'h34);
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    wait_accept(nacc);
    vecs++;
    if (nacc != 2) begin errs++; $display("FAIL ready_reassert: accept after %0d cycles, want 2", nacc); end
    wait_drain(50);
    check_last("full_last_tag", 8'h34, model_mem[7]);

    // streaming at one request per cycle
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 4'h0, 30'(i), 32'h0, 8'(i), nacc);
      vecs++;
      if (nacc != 1) begin errs++; $display("FAIL stream_accept %0d: took %0d cycles, want 1", i, nacc); end
    end
    wait_drain(50);
    check_last("stream_last", 8'd15, model_mem[15]);

    // reset with responses in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'h0, 30'(20 + i), 32'h0, 8'(8'h40 + i), nacc);
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_midstream: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    @(posedge clk); #1;
    idle(1);
    reset = 1'b1;
    rsp_ready = 1'b1;
    idle(6);
    send(1'b0, 4'h0, 30'd5, 32'h0, 8'h55, nacc);
    wait_drain(50);
    check_last("post_reset_read", 8'h55, 32'hDEADABEF);

    // write acknowledge behaviour
    send(1'b1, 4'hF, 30'd9, 32'h12345678, 8'h22, nacc);
`ifdef VX_MEM_WRITE_ACK_EN
    wait_drain(50);
    check_last("write_ack", 8'h22, 32'h0);
`else
    repeat (4) begin
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL write_no_ack: busy=%b, want 0", busy); end
    end
    @(posedge clk); #1;
`endif

    // random traffic with random backpressure and aliased addresses
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        ra = {20'($urandom_range(0, 255)), 10'($urandom_range(0, 63))};
        send(1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom, 8'($urandom), nacc);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_drain(200);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
